// File: rtl/bist_sig_controller.sv
// ---------------------------------------------------------------------------
// bist_sig_controller
//
// Runs one BIST session. It clears the MISR, enables the test pattern
// generator for NUM_PATTERNS cycles, and then compares the MISR signature
// with GOLDEN_SIG. The result is held until the next session starts or the
// block is reset.
//
// Ports
//   clock          in   rising-edge clock, shared with the MISR and TPG
//   reset          in   synchronous reset, active low
//   start          in   session request; sampled only in IDLE or DONE
//   signature      in   current MISR register value (SIG_WIDTH)
//   misr_clear     out  active-high clear to the MISR
//   tpg_en         out  pattern generator advance enable
//   busy           out  high in CLEAR, RUN and COMPARE
//   done           out  high in DONE
//   pass           out  signature matched; valid while done=1
//   fail           out  signature mismatched; valid while done=1
//   pattern_count  out  patterns applied in the current session (CNT_WIDTH)
//   sig_captured   out  signature latched at compare (SIG_WIDTH)
//   dbg_state      out  current FSM state encoding, for observation only
//
// Handshake: there is no ready/ack. start is a level that the block samples
// only in IDLE or DONE. While busy=1 the block ignores start; it does not
// queue the request and does not abort the session. done stays high until
// the next accepted start or a reset.
//
// Every output comes from a register or is decoded from the state register
// alone. No input reaches an output combinationally.
//
// NUM_PATTERNS must be in the range 1 .. 2**CNT_WIDTH-1 so that
// pattern_count can reach NUM_PATTERNS without wrapping.
// ---------------------------------------------------------------------------
module bist_sig_controller #(
  parameter int                   SIG_WIDTH    = 4,
  parameter int                   NUM_PATTERNS = 15,
  parameter int                   CNT_WIDTH    = 4,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG   = 4'b1000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SIG_WIDTH-1:0] signature,
  output logic                 misr_clear,
  output logic                 tpg_en,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [CNT_WIDTH-1:0] pattern_count,
  output logic [SIG_WIDTH-1:0] sig_captured,
  output logic [2:0]           dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // RUN ends on the edge where the counter moves from NUM_PATTERNS-1 to
  // NUM_PATTERNS. That gives exactly NUM_PATTERNS RUN cycles.
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_PATTERNS - 1);

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [SIG_WIDTH-1:0] r_sig;
  logic                 r_pass;
  logic                 r_fail;
  logic                 w_misr_clear;
  logic                 w_tpg_en;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_match;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_CLEAR;
      S_CLEAR:   w_next = S_RUN;
      S_RUN:     if (r_cnt == LAST_CNT) w_next = S_COMPARE;
      S_COMPARE: w_next = S_DONE;
      S_DONE:    if (start) w_next = S_CLEAR;
      default:   w_next = S_IDLE;
    endcase
  end

  // Output decode, from the state register only
  always_comb begin
    w_misr_clear = 1'b1;
    w_tpg_en     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE:    w_misr_clear = 1'b1;
      S_CLEAR:   w_busy       = 1'b1;
      S_RUN: begin
        w_misr_clear = 1'b0;
        w_tpg_en     = 1'b1;
        w_busy       = 1'b1;
      end
      S_COMPARE: begin
        w_misr_clear = 1'b0;
        w_busy       = 1'b1;
      end
      S_DONE:    w_done = 1'b1;
      default:   w_misr_clear = 1'b1;
    endcase
  end

  assign w_match = (signature == GOLDEN_SIG);

  // Session datapath: pattern counter and captured result.
  // The result is cleared on the edge that accepts start, not on the edge
  // that leaves CLEAR. A stale pass or fail from the previous session is
  // therefore never visible outside DONE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_sig  <= '0;
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_cnt  <= '0;
            r_pass <= 1'b0;
            r_fail <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_cnt  <= '0;
          r_pass <= 1'b0;
          r_fail <= 1'b0;
        end
        S_RUN: begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
        S_COMPARE: begin
          r_sig  <= signature;
          r_pass <= w_match;
          r_fail <= ~w_match;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign misr_clear    = w_misr_clear;
  assign tpg_en        = w_tpg_en;
  assign busy          = w_busy;
  assign done          = w_done;
  assign pass          = r_pass;
  assign fail          = r_fail;
  assign pattern_count = r_cnt;
  assign sig_captured  = r_sig;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_bist_sig_controller.sv
// ---------------------------------------------------------------------------
// tb_bist_sig_controller
//
// Directed bench for bist_sig_controller.
//
// dut0 uses the default parameters (15 patterns, golden 4'b1000).
// dut1 uses NUM_PATTERNS=1 and exercises back-to-back sessions.
//
// Each DUT is fed by a stand-in MISR. The stand-in counts captures: it
// clears on misr_clear and advances on tpg_en. It reports the golden
// signature only when exactly NUM_PATTERNS captures were taken in "good"
// mode, and reports 4'b0000 in "bad" mode, as a MISR would with all-zero
// input data.
// ---------------------------------------------------------------------------
module tb_bist_sig_controller;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [3:0] GOLD   = 4'b1000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------- dut0 (defaults) ----------------
  logic       start = 1'b0;
  logic [3:0] signature;
  logic       misr_clear, tpg_en, busy, done, pass, fail;
  logic [3:0] pattern_count, sig_captured;
  logic [2:0] dbg_state;

  bist_sig_controller dut0 (
    .clock(clock), .reset(reset), .start(start), .signature(signature),
    .misr_clear(misr_clear), .tpg_en(tpg_en), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .pattern_count(pattern_count),
    .sig_captured(sig_captured), .dbg_state(dbg_state)
  );

  // ---------------- dut1 (NUM_PATTERNS = 1) ----------------
  logic       start1 = 1'b0;
  logic [3:0] signature1;
  logic       misr_clear1, tpg_en1, busy1, done1, pass1, fail1;
  logic [3:0] pattern_count1, sig_captured1;
  logic [2:0] dbg_state1;

  bist_sig_controller #(.NUM_PATTERNS(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .signature(signature1),
    .misr_clear(misr_clear1), .tpg_en(tpg_en1), .busy(busy1), .done(done1),
    .pass(pass1), .fail(fail1), .pattern_count(pattern_count1),
    .sig_captured(sig_captured1), .dbg_state(dbg_state1)
  );

  // ---------------- stand-in MISRs ----------------
  logic [4:0] cap0 = 5'd0;
  logic [4:0] cap1 = 5'd0;
  logic       mode0 = 1'b1;
  logic       mode1 = 1'b1;

  always @(posedge clock) begin
    if (misr_clear)  cap0 <= 5'd0;
    else if (tpg_en) cap0 <= cap0 + 5'd1;
    if (misr_clear1)  cap1 <= 5'd0;
    else if (tpg_en1) cap1 <= cap1 + 5'd1;
  end

  assign signature  = mode0 ? ((cap0 == 5'd15) ? GOLD : cap0[3:0]) : 4'b0000;
  assign signature1 = mode1 ? ((cap1 == 5'd1)  ? GOLD : 4'b0111)   : 4'b0000;

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge, then settle. Checks run 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Run a full dut0 session from IDLE or DONE. If poke is set, pulse start
  // again mid-RUN; the DUT must ignore that pulse.
  task automatic run_session(input bit pass_mode, input bit poke);
    int cyc;
    int tpg;
    int busy_cnt;
    logic [3:0] exp_sig;
    mode0 = pass_mode;
    exp_q.push_back(pass_mode ? GOLD : 4'b0000);
    start = 1'b1;
    step();                       // edge E0 accepts start
    start = 1'b0;
    cyc = 1;
    tpg = 0;
    while (!done && cyc < 60) begin
      if (tpg_en) tpg++;
      start = (poke && cyc == 6);
      step();
      cyc++;
    end
    start = 1'b0;
    exp_sig = exp_q.pop_front();
    check("done_seen", done, 1);
    check("done_latency", cyc - 1, 17);
    check("tpg_cycles", tpg, 15);
    check("sig_captured", sig_captured, exp_sig);
    check("pass", pass, exp_sig == GOLD);
    check("fail", fail, exp_sig != GOLD);
    check("pattern_count", pattern_count, 15);
    check("busy_in_done", busy, 0);
    check("clear_in_done", misr_clear, 1);
    busy_cnt = 0;
    repeat (6) begin
      step();
      if (busy) busy_cnt++;
    end
    check("no_restart", busy_cnt, 0);
    check("done_hold", done, 1);
    check("pass_hold", pass, exp_sig == GOLD);
    check("sig_hold", sig_captured, exp_sig);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int w;
    int done_cnt;
    logic exp_p;

    // Reset held for 3 edges with start high.
    reset = 1'b0;
    start = 1'b1;
    repeat (3) step();
    check("rst_state", dbg_state, S_IDLE);
    check("rst_misr_clear", misr_clear, 1);
    check("rst_tpg_en", tpg_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_count", pattern_count, 0);
    check("rst_sig", sig_captured, 0);
    start = 1'b0;
    reset = 1'b1;
    step();

    // Good session from IDLE, bad session from DONE, then a good session
    // with start pulsed while busy.
    run_session(1'b1, 1'b0);
    run_session(1'b0, 1'b0);
    run_session(1'b1, 1'b1);

    // Reset in the middle of RUN.
    mode0 = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    w = 0;
    while (pattern_count != 4'd7 && w < 40) begin
      step();
      w++;
    end
    check("mid_count7", pattern_count, 7);
    check("mid_tpg_before", tpg_en, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_state", dbg_state, S_IDLE);
    check("mid_tpg_en", tpg_en, 0);
    check("mid_misr_clear", misr_clear, 1);
    check("mid_done", done, 0);
    check("mid_count", pattern_count, 0);
    done_cnt = 0;
    repeat (20) begin
      step();
      if (done) done_cnt++;
    end
    check("mid_no_done", done_cnt, 0);
    run_session(1'b1, 1'b0);

    // dut1: hold start high; the sessions repeat every 4 cycles and each
    // one evaluates pass again.
    mode1 = 1'b1;
    start1 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      w = 0;
      while (!done1 && w < 20) begin
        step();
        w++;
      end
      exp_p = mode1;
      check("b2b_done", done1, 1);
      if (s > 0) check("b2b_period", w + 1, 4);
      check("b2b_pass", pass1, exp_p);
      check("b2b_fail", fail1, !exp_p);
      check("b2b_sig", sig_captured1, exp_p ? GOLD : 4'b0000);
      check("b2b_count", pattern_count1, 1);
      mode1 = ~mode1;
      step();
      check("b2b_done_pulse", done1, 0);
      check("b2b_pass_cleared", pass1 | fail1, 0);
    end
    start1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Guard against a hang.
  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
